arm32_flag_unit: RTL
====================

# arm32_flag_unit

Architectural NZCV flag holder and condition-code evaluator for the ARM32 execute stage. It consumes the Negative/Zero/Carry/Overflow flags produced by the ALU and gates each instruction on its 4-bit condition field. It returns the current carry flag to the ALU's carry input for ADC/SBC/RSC. It has a one-entry registered output with a valid/ready handshake toward writeback, and a saturating counter of condition-failed instructions.

## Interface
- `SKIP_CNT_W`, default 16: width of the skipped-instruction counter.

Ports:
- `clk`, input, 1: system clock; all state updates on rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: execute-stage record present.
- `in_ready`, output, 1: unit can accept the record this cycle.
- `in_cond`, input, 4: ARM condition field (instr[31:28]).
- `in_set_flags`, input, 1: S bit; update NZCV if condition passes.
- `in_n`, `in_z`, `in_c`, `in_v`, input, 1 each: ALU Negative, Zero, Carry, Overflow for this record.
- `wr_en`, input, 1: direct flag write (MSR-style).
- `wr_nzcv`, input, 4: value for direct write, {N,Z,C,V}.
- `out_valid`, output, 1: result register holds a record.
- `out_ready`, input, 1: downstream consumes the result.
- `out_pass`, output, 1: condition passed for the held record.
- `nzcv`, output, 4: architectural flags {N,Z,C,V}.
- `c_flag`, output, 1: equals `nzcv[1]`; drives the ALU carry input.
- `skip_cnt`, output, SKIP_CNT_W: count of accepted records whose condition failed.
- `skip_clr`, input, 1: synchronous clear of `skip_cnt`.

## Operation
- Accept is `in_valid & in_ready`. `in_ready = ~out_valid | out_ready` (combinational; a full register that drains the same cycle can accept).
- `in_cond` is evaluated combinationally against the current `nzcv` register, before this record's update:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1.
  - F NV: 0 (never executes).
- On accept:
  - `out_pass` is loaded with the evaluation result.
  - `out_valid` is set to 1.
  - If the result passed and `in_set_flags`=1, `nzcv` is loaded with {in_n,in_z,in_c,in_v}.
  - If the result failed, `skip_cnt` increments, saturating at all-ones.
- On `out_valid & out_ready` with no accept in the same cycle, `out_valid` clears. With a simultaneous accept, `out_valid` stays 1 and the new result replaces the old.
- Direct write: if `wr_en`=1, `nzcv` is loaded from `wr_nzcv`. It overrides a same-cycle flag update from an accepted record. The record itself is still accepted and its `out_pass` is still computed from the pre-write flags.
- `skip_clr` resets `skip_cnt` to 0 and takes priority over a same-cycle increment.
- No flag hazard exists: the record after a flag-setting record is evaluated against the updated `nzcv`.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `nzcv`=4'b0000, `c_flag`=0.
  - `out_valid`=0, `out_pass`=0.
  - `skip_cnt`=0.
  - `in_ready`=1.
- Reset asserted mid-operation discards the held result immediately. No partial flag update survives.
- Latency:
  - Record accepted at edge k: `out_pass`/`out_valid` are visible after edge k.
  - `nzcv` and `c_flag` reflect the update after edge k.
  - A record accepted at edge k+1 sees the new flags.
- Throughput is one record per cycle while `out_ready`=1.
- Backpressure: `out_valid`=1 with `out_ready`=0 holds `out_pass` stable and drives `in_ready`=0. No state changes from `in_*` while stalled.
- `wr_en` and `skip_clr` act every cycle regardless of stall.
- `c_flag` and `nzcv` are pure register outputs with no combinational path from inputs.

## Test plan
- Reset then single accept: `in_cond`=E, `in_set_flags`=1, NZCV inputs 4'b0110, `out_ready`=1 -> next cycle `out_pass`=1, `nzcv`=0110, `c_flag`=1, `skip_cnt`=0.
- Condition sweep: for each `nzcv` in {0000,0100,0010,1001,1000,0001}, sweep `in_cond` 0..F with `in_set_flags`=0 -> `out_pass` matches the condition list above every time, NV always 0, and `nzcv` unchanged.
- Failed conditional set: `nzcv`=0100, `in_cond`=1 (NE), `in_set_flags`=1, inputs 1111 -> `out_pass`=0, `nzcv` remains 0100, `skip_cnt` increments by 1.
- Back-to-back dependency: cycle 0 accept CMP-like record (AL, S=1, inputs 0110); cycle 1 accept EQ record -> cycle-1 record passes. Also check ADC-path `c_flag`=1 from cycle 1.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, `out_pass` and `nzcv` frozen. Release `out_ready` -> the pending record is accepted the same cycle and no record is lost or duplicated.
- Priority and saturation:
  - Same-cycle `wr_en` with `wr_nzcv`=1001 and an accepted AL S=1 record with inputs 0110 -> `nzcv`=1001.
  - With `SKIP_CNT_W`=2, five failed records -> `skip_cnt`=3.
  - `skip_clr` together with a failed record -> `skip_cnt`=0.

Source files
------------

// File: rtl/arm32_flag_unit.sv
// arm32_flag_unit: architectural NZCV holder, ARM condition-code evaluator,
// one-entry registered result toward writeback, and a saturating counter of
// condition-failed records.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds valid and its payload until that edge. Ready never
// depends on valid. Here in_ready = ~out_valid | out_ready, so a full result
// register that drains in a cycle can take a new record in the same cycle.
module arm32_flag_unit #(
  parameter int SKIP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_cond,
  input  logic                  in_set_flags,
  input  logic                  in_n,
  input  logic                  in_z,
  input  logic                  in_c,
  input  logic                  in_v,
  input  logic                  wr_en,
  input  logic [3:0]            wr_nzcv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_pass,
  output logic [3:0]            nzcv,
  output logic                  c_flag,
  output logic [SKIP_CNT_W-1:0] skip_cnt,
  input  logic                  skip_clr
);

  logic accept;
  logic cond_pass;
  logic flag_n, flag_z, flag_c, flag_v;

  assign flag_n = nzcv[3];
  assign flag_z = nzcv[2];
  assign flag_c = nzcv[1];
  assign flag_v = nzcv[0];

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign c_flag   = nzcv[1];

  // Condition check against the flags held before this record's update.
  always_comb begin
    cond_pass = 1'b0;
    case (in_cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = ~flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = ~flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = ~flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = ~flag_v;
      4'h8: cond_pass = flag_c & ~flag_z;
      4'h9: cond_pass = ~flag_c | flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
      4'hD: cond_pass = flag_z | (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Result register: load on accept, drain when consumed without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pass  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pass  <= cond_pass;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Flag register: direct write wins over a record's flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv <= 4'b0000;
    end else if (wr_en) begin
      nzcv <= wr_nzcv;
    end else if (accept && cond_pass && in_set_flags) begin
      nzcv <= {in_n, in_z, in_c, in_v};
    end
  end

  // Skipped-record counter: clear wins, increment saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= '0;
    end else if (skip_clr) begin
      skip_cnt <= '0;
    end else if (accept && !cond_pass && (skip_cnt != {SKIP_CNT_W{1'b1}})) begin
      skip_cnt <= skip_cnt + 1'b1;
    end
  end

endmodule
